irq_arbiter: RTL

- Multi-source interrupt arbiter that drives the single `interrupter` input of `RV32core`.
- Synchronises up to `N_SRC` external interrupt lines and latches them per source as edge- or level-triggered.
- Picks the highest-priority enabled pending source (lowest index wins) and runs a claim/complete handshake with the core over a small register port.
- The core sees one interrupt at a time and never loses edge events.

---
 rtl/irq_arbiter_if.sv | 15 +
 rtl/irq_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/irq_arbiter_if.sv
// Register port between the core and irq_arbiter: one-cycle sel strobe, rdata
// registered and valid the cycle after a read strobe.
interface irq_arbiter_if;
  // Handshake: an access happens on every rising edge where sel is high; there is
  // no stall, so sel must be held for exactly one cycle per access. rdata is
  // updated on that edge for reads and otherwise holds its last read value.
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output we, output addr, output wdata, input rdata);
  modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/irq_arbiter.sv
// Multi-source interrupt arbiter: synchronises src lines, latches them as edge or
// level pending, and hands the lowest-index enabled one to the core via claim/complete.
module irq_arbiter #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  irq_arbiter_if.slave     bus,
  output logic             interrupter,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state;
  logic [N_SRC-1:0] s1, s2, s3;
  logic [N_SRC-1:0] pending, enable, mode;
  logic [N_SRC-1:0] cand, svc_mask, rise, claim_clr, mode_chg, wdata_n;
  logic [4:0]       id, claim_id;
  logic             has_cand, rd, wr, claim_rd, complete_wr, claim_fire;

  assign wdata_n   = bus.wdata[N_SRC-1:0];
  assign dbg_state = state;

  always_comb begin
    rd          = bus.sel & ~bus.we;
    wr          = bus.sel & bus.we;
    claim_rd    = rd && (bus.addr == 2'd3);
    complete_wr = wr && (bus.addr == 2'd3) && (bus.wdata == {27'd0, claim_id + 5'd1});
    svc_mask    = '0;
    for (int i = 0; i < N_SRC; i++)
      svc_mask[i] = (state == SERVICE) && (claim_id == 5'(i));
    cand     = pending & enable & ~svc_mask;
    has_cand = |cand;
    id       = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (cand[i]) id = 5'(i);
    claim_fire = (state == ASSERT) && claim_rd && has_cand;
    claim_clr  = '0;
    for (int i = 0; i < N_SRC; i++)
      claim_clr[i] = claim_fire && (id == 5'(i)) && mode[i];
    rise     = s2 & ~s3;
    mode_chg = (wr && (bus.addr == 2'd2)) ? (mode ^ wdata_n) : '0;
  end

  // Edge sources: a new rise beats a same-cycle claim clear. A mode change wipes the bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      pending <= '0;
      enable  <= '0;
      mode    <= '0;
    end else begin
      s1      <= src;
      s2      <= s1;
      s3      <= s2;
      pending <= ~mode_chg & ((mode & ((pending & ~claim_clr) | rise)) | (~mode & s2));
      if (wr && (bus.addr == 2'd0)) enable <= wdata_n;
      if (wr && (bus.addr == 2'd2)) mode   <= wdata_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      interrupter <= 1'b0;
      busy        <= 1'b0;
      claim_id    <= '0;
      bus.rdata   <= '0;
    end else begin
      if (rd) begin
        case (bus.addr)
          2'd0:    bus.rdata <= 32'(enable);
          2'd1:    bus.rdata <= 32'(pending);
          2'd2:    bus.rdata <= 32'(mode);
          default: bus.rdata <= claim_fire ? {27'd0, id + 5'd1} : 32'd0;
        endcase
      end
      case (state)
        IDLE: begin
          if (has_cand) begin
            state       <= ASSERT;
            interrupter <= 1'b1;
          end
        end
        ASSERT: begin
          // id is live here, so a higher-priority arrival before the claim wins.
          if (claim_fire) begin
            claim_id    <= id;
            state       <= SERVICE;
            interrupter <= 1'b0;
            busy        <= 1'b1;
          end else if (!has_cand) begin
            state       <= IDLE;
            interrupter <= 1'b0;
          end
        end
        SERVICE: begin
          if (complete_wr) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          interrupter <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
